// File: rtl/write_back_stage.sv
// Write-back stage of the 32-bit pipelined MIPS core.
// Picks the register-file write value from the link address, HI/LO, extracted
// load data or the ALU result. It also qualifies the register write, and keeps
// a one-cycle registered copy of the last committed write for forwarding.
module write_back_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemtoReg,
    input  logic [DATA_WIDTH-1:0]     readData,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic                      RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] writeReg,
    input  logic [2:0]                loadType,
    input  logic                      Link,
    input  logic [DATA_WIDTH-1:0]     linkAddr,
    input  logic [1:0]                HiLoSel,
    input  logic [DATA_WIDTH-1:0]     hi,
    input  logic [DATA_WIDTH-1:0]     lo,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic                      regWriteOut,
    output logic [REG_ADDR_WIDTH-1:0] writeRegOut,
    output logic                      fwdValid,
    output logic [REG_ADDR_WIDTH-1:0] fwdReg,
    output logic [DATA_WIDTH-1:0]     fwdData
);

    localparam logic [2:0] LD_WORD = 3'b000;
    localparam logic [2:0] LD_BS   = 3'b001;
    localparam logic [2:0] LD_BU   = 3'b010;
    localparam logic [2:0] LD_HS   = 3'b011;
    localparam logic [2:0] LD_HU   = 3'b100;

    logic [1:0]                offset;
    logic signed [7:0]         load_byte;
    logic signed [15:0]        load_half;
    logic [DATA_WIDTH-1:0]     load_data;

    logic                      fwd_valid_q, fwd_valid_d;
    logic [REG_ADDR_WIDTH-1:0] fwd_reg_q,   fwd_reg_d;
    logic [DATA_WIDTH-1:0]     fwd_data_q,  fwd_data_d;

    assign offset = ALUResult[1:0];

    // Lane extraction: byte lane by full offset, half lane by offset[1] only.
    always_comb begin
        load_byte = 8'sd0;
        load_half = 16'sd0;
        case (offset)
            2'd0:    load_byte = readData[7:0];
            2'd1:    load_byte = readData[15:8];
            2'd2:    load_byte = readData[23:16];
            default: load_byte = readData[31:24];
        endcase
        if (offset[1]) begin
            load_half = readData[31:16];
        end else begin
            load_half = readData[15:0];
        end
    end

    // Sign/zero extension by load type; unlisted or unknown encodings load the whole word.
    always_comb begin
        load_data = readData;
        case (loadType)
            LD_BS:   load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            LD_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            LD_HS:   load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            LD_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
            LD_WORD: load_data = readData;
            default: load_data = readData;
        endcase
    end

    // Write-value source select. An unknown Link fails the if test, and an unknown
    // HiLoSel matches no case item, so both fall through to the load/ALU mux.
    always_comb begin
        writeData = MemtoReg ? load_data : ALUResult;
        if (Link == 1'b1) begin
            writeData = linkAddr;
        end else begin
            case (HiLoSel)
                2'b01:   writeData = hi;
                2'b10:   writeData = lo;
                default: writeData = MemtoReg ? load_data : ALUResult;
            endcase
        end
    end

    assign regWriteOut = RegWrite && (writeReg != '0);
    assign writeRegOut = writeReg;

    assign fwd_valid_d = regWriteOut;
    assign fwd_reg_d   = writeReg;
    assign fwd_data_d  = writeData;

    // Forwarding copy of this cycle's write; reset drops any pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_reg_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_reg_q   <= fwd_reg_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwdValid = fwd_valid_q;
    assign fwdReg   = fwd_reg_q;
    assign fwdData  = fwd_data_q;

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

    logic        clk;
    logic        rst;
    logic        MemtoReg;
    logic [31:0] readData;
    logic [31:0] ALUResult;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [2:0]  loadType;
    logic        Link;
    logic [31:0] linkAddr;
    logic [1:0]  HiLoSel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] writeData;
    logic        regWriteOut;
    logic [4:0]  writeRegOut;
    logic        fwdValid;
    logic [4:0]  fwdReg;
    logic [31:0] fwdData;

    int tests;
    int fails;

    write_back_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .MemtoReg(MemtoReg), .readData(readData),
        .ALUResult(ALUResult), .RegWrite(RegWrite), .writeReg(writeReg),
        .loadType(loadType), .Link(Link), .linkAddr(linkAddr), .HiLoSel(HiLoSel),
        .hi(hi), .lo(lo), .writeData(writeData), .regWriteOut(regWriteOut),
        .writeRegOut(writeRegOut), .fwdValid(fwdValid), .fwdReg(fwdReg),
        .fwdData(fwdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [2:0]  lt;
        logic        lnk;
        logic [31:0] la;
        logic [1:0]  hls;
        logic [31:0] h;
        logic [31:0] l;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] exp_wd;
        logic        exp_rwo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic m2r, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [2:0] lt, input logic lnk,
                       input logic [1:0] hls, input logic rw, input logic [4:0] wr,
                       input logic [31:0] exp_wd, input logic exp_rwo);
        vec_t v;
        v.name = name; v.m2r = m2r; v.rd = rd; v.alu = alu; v.lt = lt; v.lnk = lnk;
        v.la = 32'h0040_0108; v.hls = hls; v.h = 32'hAAAA_0001; v.l = 32'h5555_0002;
        v.rw = rw; v.wr = wr; v.exp_wd = exp_wd; v.exp_rwo = exp_rwo;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        MemtoReg = v.m2r; readData = v.rd; ALUResult = v.alu; loadType = v.lt;
        Link = v.lnk; linkAddr = v.la; HiLoSel = v.hls; hi = v.h; lo = v.l;
        RegWrite = v.rw; writeReg = v.wr;
    endtask

    // Reference: arithmetic view of the write-value rules.
    function automatic logic [31:0] model_wd(input vec_t v);
        longint val;
        int     off;
        if (v.lnk) return v.la;
        if (v.hls == 2'b01) return v.h;
        if (v.hls == 2'b10) return v.l;
        if (!v.m2r) return v.alu;
        off = int'(v.alu[1:0]);
        case (v.lt)
            3'd1, 3'd2: begin
                val = (longint'(v.rd) >> (8 * off)) & 255;
                if (v.lt == 3'd1 && val >= 128) val = val - 256;
                return val[31:0];
            end
            3'd3, 3'd4: begin
                val = (longint'(v.rd) >> ((off >= 2) ? 16 : 0)) & 65535;
                if (v.lt == 3'd3 && val >= 32768) val = val - 65536;
                return val[31:0];
            end
            default: return v.rd;
        endcase
    endfunction

    initial begin
        vec_t v;
        logic [31:0] exp_wd;
        logic        exp_v;
        tests = 0;
        fails = 0;

        add("byte_s_off1",   1, 32'h80FF7F01, 32'h1001, 3'b001, 0, 2'b00, 1, 5'd3, 32'h0000007F, 1);
        add("byte_u_off1",   1, 32'h80FF7F01, 32'h1001, 3'b010, 0, 2'b00, 1, 5'd3, 32'h0000007F, 1);
        add("byte_s_off3",   1, 32'h80FF7F01, 32'h1003, 3'b001, 0, 2'b00, 1, 5'd3, 32'hFFFFFF80, 1);
        add("byte_u_off2",   1, 32'h80FF7F01, 32'h1002, 3'b010, 0, 2'b00, 1, 5'd3, 32'h000000FF, 1);
        add("byte_s_off0",   1, 32'h80FF7F81, 32'h1000, 3'b001, 0, 2'b00, 1, 5'd3, 32'hFFFFFF81, 1);
        add("half_s_off0",   1, 32'h8001FFFE, 32'h2000, 3'b011, 0, 2'b00, 1, 5'd4, 32'hFFFFFFFE, 1);
        add("half_u_off2",   1, 32'h8001FFFE, 32'h2002, 3'b100, 0, 2'b00, 1, 5'd4, 32'h00008001, 1);
        add("half_s_off3",   1, 32'h8001FFFE, 32'h2003, 3'b011, 0, 2'b00, 1, 5'd4, 32'hFFFF8001, 1);
        add("half_u_off1",   1, 32'h8001FFFE, 32'h2001, 3'b100, 0, 2'b00, 1, 5'd4, 32'h0000FFFE, 1);
        add("ld_type111",    1, 32'h8001FFFE, 32'h2002, 3'b111, 0, 2'b00, 1, 5'd4, 32'h8001FFFE, 1);
        add("ld_word",       1, 32'hDEADBEEF, 32'h2003, 3'b000, 0, 2'b00, 1, 5'd4, 32'hDEADBEEF, 1);
        add("prio_link",     1, 32'h11111111, 32'h2222, 3'b000, 1, 2'b01, 1, 5'd31, 32'h00400108, 1);
        add("prio_hi",       1, 32'h11111111, 32'h2222, 3'b000, 0, 2'b01, 1, 5'd5, 32'hAAAA0001, 1);
        add("prio_lo",       1, 32'h11111111, 32'h2222, 3'b000, 0, 2'b10, 1, 5'd5, 32'h55550002, 1);
        add("hls11_mem",     1, 32'h11111111, 32'h2222, 3'b000, 0, 2'b11, 1, 5'd5, 32'h11111111, 1);
        add("alu_path",      0, 32'h11111111, 32'h2222, 3'b001, 0, 2'b00, 0, 5'd6, 32'h00002222, 0);
        add("wr_r0",         0, 32'h0, 32'h77, 3'b000, 0, 2'b00, 1, 5'd0, 32'h00000077, 0);

        // Reset state: asynchronous reset held across edges.
        rst = 1'b1;
        MemtoReg = 0; readData = 0; ALUResult = 0; RegWrite = 0; writeReg = 0;
        loadType = 0; Link = 0; linkAddr = 0; HiLoSel = 0; hi = 0; lo = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fwdValid", {31'd0, fwdValid}, 32'd0);
        chk("rst_fwdReg",   {27'd0, fwdReg},   32'd0);
        chk("rst_fwdData",  fwdData,           32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational follow with no clock edge.
        @(negedge clk);
        MemtoReg = 0; readData = 32'd2; ALUResult = 32'd3;
        #1 chk("comb_alu", writeData, 32'd3);
        #100;
        MemtoReg = 1;
        #1 chk("comb_mem_noclk", writeData, 32'd2);

        // Table vectors, each also checked through the forward registers.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk({vecs[i].name, "_wd"},  writeData, vecs[i].exp_wd);
            chk({vecs[i].name, "_rwo"}, {31'd0, regWriteOut}, {31'd0, vecs[i].exp_rwo});
            chk({vecs[i].name, "_wro"}, {27'd0, writeRegOut}, {27'd0, vecs[i].wr});
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_fv"}, {31'd0, fwdValid}, {31'd0, vecs[i].exp_rwo});
            chk({vecs[i].name, "_fd"}, fwdData, vecs[i].exp_wd);
        end

        // Write commit then forward capture.
        @(negedge clk);
        MemtoReg = 0; Link = 0; HiLoSel = 0; RegWrite = 1; writeReg = 5'd9;
        ALUResult = 32'h1234;
        @(posedge clk);
        #1;
        chk("commit_fv", {31'd0, fwdValid}, 32'd1);
        chk("commit_fr", {27'd0, fwdReg},   32'd9);
        chk("commit_fd", fwdData,           32'h1234);

        // Mid-cycle reset clears immediately and holds across edges.
        #2 rst = 1'b1;
        #1;
        chk("arst_fv", {31'd0, fwdValid}, 32'd0);
        chk("arst_fr", {27'd0, fwdReg},   32'd0);
        chk("arst_fd", fwdData,           32'd0);
        chk("arst_comb_wd", writeData, 32'h1234);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_fv", {31'd0, fwdValid}, 32'd0);
        chk("arst_hold_fd", fwdData,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        writeReg = 5'd12; ALUResult = 32'hCAFE_0000;
        @(posedge clk);
        #1;
        chk("post_rst_fv", {31'd0, fwdValid}, 32'd1);
        chk("post_rst_fr", {27'd0, fwdReg},   32'd12);
        chk("post_rst_fd", fwdData,           32'hCAFE0000);

        // Randomized vectors against the reference model.
        for (int n = 0; n < 300; n++) begin
            v.name = "rand";
            v.m2r = 1'($urandom); v.rd = $urandom; v.alu = $urandom;
            v.lt = 3'($urandom_range(0, 7));
            v.lnk = ($urandom_range(0, 7) == 0);
            v.la = $urandom;
            v.hls = 2'($urandom);
            v.h = $urandom; v.l = $urandom;
            v.rw = 1'($urandom);
            v.wr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            exp_wd = model_wd(v);
            exp_v  = v.rw && (v.wr != 5'd0);
            @(negedge clk);
            drive(v);
            #1;
            chk("rand_wd",  writeData, exp_wd);
            chk("rand_rwo", {31'd0, regWriteOut}, {31'd0, exp_v});
            @(posedge clk);
            #1;
            chk("rand_fv", {31'd0, fwdValid}, {31'd0, exp_v});
            chk("rand_fr", {27'd0, fwdReg},   {27'd0, v.wr});
            chk("rand_fd", fwdData,           exp_wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- WB stage of the 32-bit pipelined MIPS core.
- Selects the register-file write value from ALU result, memory load data (with sub-word extraction/extension), link address or HI/LO multiply results, and qualifies the register write.
- Also holds a one-cycle registered copy of the last committed write, for WB-to-ID/EX forwarding across the register-file write/read boundary.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
MemtoReg  in  1  1 = write load data, 0 = write ALU result
readData  in  32  raw word read from data memory
ALUResult  in  32  ALU result; also the load address (bits [1:0] = byte offset)
RegWrite  in  1  register write request from MEM/WB
writeReg  in  5  destination register index
loadType  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned
Link  in  1  write linkAddr (JAL/JALR)
linkAddr  in  32  PC+8 link value
HiLoSel  in  2  01 = write hi, 10 = write lo, other = none
hi  in  32  HI register from the Booth multiplier
lo  in  32  LO register from the Booth multiplier
writeData  out  32  value to the register file (combinational)
regWriteOut  out  1  qualified write enable (combinational)
writeRegOut  out  5  destination index (combinational passthrough)
fwdValid  out  1  registered: a write committed last cycle
fwdReg  out  5  registered destination of that write
fwdData  out  32  registered data of that write

Behaviour:
- writeData is purely combinational with zero latency; it follows input changes without a clock edge.
- Source priority, highest first: Link=1 -> linkAddr; HiLoSel=01 -> hi; HiLoSel=10 -> lo; MemtoReg=1 -> load data; otherwise ALUResult.
- Load data is selected by loadType, with offset = ALUResult[1:0]:
  - Word: readData unchanged.
  - Byte: readData[8*offset+7 : 8*offset], sign- or zero-extended to 32 bits.
  - Half: offset[1] selects the upper half (bits 31:16) or lower half (bits 15:0), then sign- or zero-extended; offset[0] is ignored.
- Any loadType encoding not listed, including X/Z, is treated as word.
- Link and HiLoSel at X/Z are treated as 0 / none. With only MemtoReg, readData and ALUResult driven, the block is therefore a plain 2:1 mux.
- regWriteOut = RegWrite AND (writeReg != 0). Writes to $0 are suppressed.
- writeRegOut = writeReg.
- On each rising clk:
  - fwdValid <= regWriteOut
  - fwdReg <= writeReg
  - fwdData <= writeData
  - Registers update even when fwdValid becomes 0.
- rst=1, asynchronous: fwdValid, fwdReg and fwdData are forced to 0 immediately and held while rst is asserted. The combinational outputs are unaffected by rst.
- Reset asserted mid-operation discards the pending forward entry. The first edge after deassertion captures normally.

Test Plan:
1. MemtoReg=0, readData=2, ALUResult=3 -> writeData=3. After 100 ns set MemtoReg=1 with no clock edge -> writeData=2 immediately.
2. MemtoReg=1, readData=0x80FF7F01, ALUResult offset 1, loadType=001 -> 0x0000007F; with loadType=010 -> 0x0000007F. Offset 3, byte signed -> 0xFFFFFF80.
3. Half loads: readData=0x8001FFFE. Offset 0, half signed -> 0xFFFFFFFE. Offset 2, half unsigned -> 0x00008001. loadType=111 -> 0x8001FFFE.
4. Priority: Link=1, HiLoSel=01, MemtoReg=1 -> linkAddr. Then Link=0 -> hi. Then HiLoSel=10 -> lo.
5. RegWrite=1, writeReg=0 -> regWriteOut=0, and fwdValid=0 after the edge. writeReg=9, ALUResult=0x1234 -> after the edge fwdValid=1, fwdReg=9, fwdData=0x1234.
6. With fwd registers loaded, assert rst between edges -> all fwd outputs become 0 immediately and stay 0 across edges until rst deasserts.
